// File: rtl/sevenseg_scan_decoder_if.sv
// Bus between a multiplexed common-anode display and the scan decoder:
// raw active-low segment/anode lines in, decoded per-digit registers out.
interface sevenseg_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          segments;
    logic [DIGITS-1:0]   anodes;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0]   valid;
    logic [DIGITS-1:0]   error;
    logic                update;

    modport master (output segments, anodes, input digits, valid, error, update);
    modport slave  (input segments, anodes, output digits, valid, error, update);
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Reads back a multiplexed common-anode seven-segment bus: synchronise,
// debounce each anode/segment combination, and decode hex glyphs per digit.

module sevenseg_digit_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       cap,
    input  logic       hit,
    input  logic       blank,
    input  logic [3:0] val,
    output logic [3:0] digit,
    output logic       valid,
    output logic       error
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
            valid <= 1'b0;
            error <= 1'b0;
        end else if (cap) begin
            // blank and unrecognised patterns leave the last good value in place
            if (hit) begin
                digit <= val;
                valid <= 1'b1;
                error <= 1'b0;
            end else begin
                valid <= 1'b0;
                error <= !blank;
            end
        end
    end
endmodule

module sevenseg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input logic                   clk,
    input logic                   rst,
    sevenseg_scan_decoder_if.slave bus
);
    localparam int          W   = DIGITS + 7;
    localparam logic [3:0]  STB = 4'(STABLE_CYCLES);

    typedef enum logic {COUNTING, CAPTURED} run_t;

    // {anodes, segments}; all-ones means blank with no digit selected
    logic [W-1:0] s1, s2, p;
    logic [3:0]   cnt, cnt_nxt;
    run_t         state;
    logic         sel, changed, cap;
    logic [3:0]   val;
    logic         hit, blank;
    logic [DIGITS-1:0][3:0] dig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '1;
            s2 <= '1;
            p  <= '1;
        end else begin
            s1 <= {bus.anodes, bus.segments};
            s2 <= s1;
            p  <= s2;
        end
    end

    assign sel     = ($countones(~s2[W-1:7]) == 1);
    assign changed = (s2 != p);

    always_comb begin
        cnt_nxt = '0;
        cap     = 1'b0;
        if (sel) begin
            if (changed)        cnt_nxt = 4'd1;
            else if (cnt < STB) cnt_nxt = cnt + 4'd1;
            else                cnt_nxt = cnt;
            // a changed sample opens a new run, so any earlier capture no longer blocks
            cap = (cnt_nxt == STB) && (changed || state == COUNTING);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            state      <= COUNTING;
            bus.update <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            bus.update <= cap;
            if (!sel)        state <= COUNTING;
            else if (cap)    state <= CAPTURED;
            else if (changed) state <= COUNTING;
        end
    end

    always_comb begin
        hit   = 1'b1;
        val   = '0;
        blank = (s2[6:0] == 7'h7F);
        case (s2[6:0])
            7'h40: val = 4'h0;
            7'h79: val = 4'h1;
            7'h24: val = 4'h2;
            7'h30: val = 4'h3;
            7'h19: val = 4'h4;
            7'h12: val = 4'h5;
            7'h02: val = 4'h6;
            7'h78: val = 4'h7;
            7'h00: val = 4'h8;
            7'h10: val = 4'h9;
            7'h08: val = 4'hA;
            7'h03: val = 4'hB;
            7'h46: val = 4'hC;
            7'h21: val = 4'hD;
            7'h06: val = 4'hE;
            7'h0E: val = 4'hF;
            default: hit = 1'b0;
        endcase
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        sevenseg_digit_reg u_reg (
            .clk   (clk),
            .rst   (rst),
            .cap   (cap && !s2[7+i]),
            .hit   (hit),
            .blank (blank),
            .val   (val),
            .digit (dig[i]),
            .valid (bus.valid[i]),
            .error (bus.error[i])
        );
    end

    assign bus.digits = dig;
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Randomised and directed checks of the scan decoder against a sample-history
// reference model: capture fires when a selected sample run reaches STABLE_CYCLES.
module tb_sevenseg_scan_decoder;
    localparam int DIGITS = 4;
    localparam int STB    = 3;

    typedef logic [DIGITS+6:0] samp_t;

    logic clk = 1'b0;
    logic rst;
    sevenseg_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

    sevenseg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16];
    samp_t      hist [$];
    logic [DIGITS-1:0][3:0] m_dig;
    logic [DIGITS-1:0]      m_val, m_err;
    logic                   m_upd;
    int checks = 0, errors = 0, upd_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back('1);
        m_dig = '0;
        m_val = '0;
        m_err = '0;
        m_upd = 1'b0;
    endtask

    // Called just after each active edge: the sample taken two edges ago is the
    // one whose run length decides capture at this edge.
    task automatic model_edge();
        samp_t v;
        int idx, run, zeros, d;
        bit found;
        hist.push_back({bus.anodes, bus.segments});
        if (hist.size() > 40) void'(hist.pop_front());
        idx   = hist.size() - 3;
        v     = hist[idx];
        m_upd = 1'b0;
        zeros = 0;
        d     = 0;
        for (int i = 0; i < DIGITS; i++) if (!v[7+i]) begin zeros++; d = i; end
        if (zeros == 1) begin
            run = 0;
            for (int j = idx; j >= 0 && hist[j] == v && run <= STB; j--) run++;
            if (run == STB) begin
                m_upd = 1'b1;
                found = 1'b0;
                for (int g = 0; g < 16; g++)
                    if (glyph[g] == v[6:0]) begin found = 1'b1; m_dig[d] = 4'(g); end
                m_val[d] = found;
                m_err[d] = !found && (v[6:0] != 7'h7F);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".digits"}, 32'(bus.digits), 32'(m_dig));
        chk({tag, ".valid"},  32'(bus.valid),  32'(m_val));
        chk({tag, ".error"},  32'(bus.error),  32'(m_err));
        chk({tag, ".update"}, 32'(bus.update), 32'(m_upd));
        if (bus.update) upd_seen++;
    endtask

    task automatic step(input logic [DIGITS-1:0] an, input logic [6:0] seg, input int n,
                        input string tag);
        for (int k = 0; k < n; k++) begin
            bus.anodes   = an;
            bus.segments = seg;
            @(posedge clk);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    initial begin
        logic [6:0] code [4];
        int base;
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        code  = '{7'h46, 7'h40, 7'h21, 7'h06};

        // reset and idle
        rst = 1'b1;
        bus.anodes   = '1;
        bus.segments = '1;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1 rst = 1'b0;
        step('1, '1, 5, "idle");

        // single digit "3"
        base = upd_seen;
        step(4'b1110, 7'h30, 6, "d0_three");
        chk("d0_three.val3", 32'(bus.digits[3:0]), 32'h3);
        chk("d0_three.pulses", 32'(upd_seen - base), 32'd1);
        step('1, '1, 3, "d0_idle");
        chk("d0_idle.pulses", 32'(upd_seen - base), 32'd1);

        // scan "C0dE"
        base = upd_seen;
        for (int d = 0; d < 4; d++) begin
            step(~(4'b1 << d), code[d], 5, "scan");
            step('1, '1, 1, "scan_gap");
        end
        step('1, '1, 2, "scan_idle");
        chk("scan.digits", 32'(bus.digits), 32'hED0C);
        chk("scan.valid",  32'(bus.valid),  32'hF);
        chk("scan.pulses", 32'(upd_seen - base), 32'd4);

        // unrecognised pattern on digit 1
        step(4'b1101, 7'h7E, 5, "bad");
        step('1, '1, 3, "bad_idle");
        chk("bad.error", 32'(bus.error), 32'h2);
        chk("bad.valid", 32'(bus.valid), 32'hD);
        chk("bad.keep",  32'(bus.digits[7:4]), 32'h0);

        // short glitch and multi-select never capture
        base = upd_seen;
        step(4'b1110, 7'h79, 2, "glitch");
        step('1, '1, 4, "glitch_idle");
        step(4'b1100, 7'h30, 10, "multi");
        step('1, '1, 3, "multi_idle");
        chk("glitch.pulses", 32'(upd_seen - base), 32'd0);

        // digit 2 shows 8, then reset lands mid-run of a "4"
        step(4'b1011, 7'h00, 5, "d2_eight");
        step('1, '1, 2, "d2_idle");
        chk("d2_eight.val", 32'(bus.digits[11:8]), 32'h8);
        step(4'b1011, 7'h19, 2, "d2_run");
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk); #1 rst = 1'b0;
        step(4'b1011, 7'h19, 4, "post_rst_wait");
        chk("post_rst.early", 32'(bus.valid), 32'h0);
        step(4'b1011, 7'h19, 1, "post_rst_cap");
        chk("post_rst.digits", 32'(bus.digits), 32'h0400);
        chk("post_rst.valid",  32'(bus.valid),  32'h4);

        // randomised scans: glyphs, blanks, junk, multi-select, short holds
        for (int it = 0; it < 80; it++) begin
            logic [DIGITS-1:0] an;
            logic [6:0] seg;
            int kind;
            an   = ~(DIGITS'(1) << $urandom_range(0, DIGITS-1));
            kind = $urandom_range(0, 9);
            if (kind < 6)       seg = glyph[$urandom_range(0, 15)];
            else if (kind == 6) seg = 7'h7F;
            else if (kind == 7) seg = 7'($urandom);
            else if (kind == 8) begin seg = glyph[$urandom_range(0, 15)]; an = DIGITS'($urandom); end
            else                seg = glyph[$urandom_range(0, 15)];
            step(an, seg, $urandom_range(1, 6), "rand");
            if ($urandom_range(0, 2) != 0) step('1, '1, $urandom_range(1, 2), "rand_gap");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
